// File: rtl/pipeline_hazard_controller_if.sv
// Signal bundle between the semiMIPS pipeline datapath and the hazard controller.
// The datapath side (master) drives the ID/EX hazard flags; the controller
// side (slave) returns the pipeline enables, the mul/div handshake and the
// stall counter. dbg_state/dbg_mdcnt expose the controller FSM for checkers.
interface pipeline_hazard_controller_if #(
  parameter int REGW   = 5,
  parameter int CNTW   = 6,
  parameter int STALLW = 16
);
  logic [REGW-1:0]   idexrt;
  logic              idexmemrd;
  logic [REGW-1:0]   ifidrs;
  logic [REGW-1:0]   ifidrt;
  logic              idexmd;
  logic              ifidmd;
  logic              ifidhilo;
  logic              branchtaken;
  logic              stallclr;
  logic              pcen;
  logic              ifiden;
  logic              ifidflush;
  logic              ctrlsig;
  logic              mdstart;
  logic              mdbusy;
  logic              mddone;
  logic [STALLW-1:0] stallcount;
  logic              dbg_state;
  logic [CNTW-1:0]   dbg_mdcnt;

  modport master (
    output idexrt, idexmemrd, ifidrs, ifidrt, idexmd, ifidmd, ifidhilo,
           branchtaken, stallclr,
    input  pcen, ifiden, ifidflush, ctrlsig, mdstart, mdbusy, mddone,
           stallcount, dbg_state, dbg_mdcnt
  );

  modport slave (
    input  idexrt, idexmemrd, ifidrs, ifidrt, idexmd, ifidmd, ifidhilo,
           branchtaken, stallclr,
    output pcen, ifiden, ifidflush, ctrlsig, mdstart, mdbusy, mddone,
           stallcount, dbg_state, dbg_mdcnt
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage semiMIPS pipeline: load-use detection,
// mul/div busy-window ownership, branch squash and a saturating stall counter.
//
// Mul/div handshake: mdstart is a single-cycle pulse issued only from RUN when
// the EX instruction is a mul/div; mdbusy is high for exactly MDCYCLES cycles
// starting on the following cycle; mddone pulses on the last of those cycles,
// while mdbusy is still high. There is no back-pressure on the unit.
module pipeline_hazard_controller #(
  parameter int REGW     = 5,
  parameter int MDCYCLES = 32,
  parameter int CNTW     = 6,
  parameter int STALLW   = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  pipeline_hazard_controller_if.slave  hz
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_MDWAIT = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNTW-1:0]   r_mdcnt;
  logic [STALLW-1:0] r_stallcount;

  logic w_loaduse;
  logic w_busy;
  logic w_mdhaz;
  logic w_stall;
  logic w_pcen;
  logic w_ifiden;
  logic w_ifidflush;
  logic w_ctrlsig;
  logic w_mdstart;
  logic w_mddone;

  // Hazard terms; register 0 never produces a load-use stall.
  always_comb begin
    w_loaduse = hz.idexmemrd && (hz.idexrt != '0) &&
                ((hz.idexrt == hz.ifidrs) || (hz.idexrt == hz.ifidrt));
    w_busy    = (r_state == ST_MDWAIT);
    w_mdhaz   = w_busy && (hz.ifidmd || hz.ifidhilo);
    w_stall   = w_loaduse || w_mdhaz;
  end

  // Pipeline enables: reset bubble, then branch squash over stall over run.
  always_comb begin
    w_pcen      = 1'b0;
    w_ifiden    = 1'b0;
    w_ifidflush = 1'b0;
    w_ctrlsig   = 1'b1;
    w_mdstart   = 1'b0;
    w_mddone    = 1'b0;
    if (rstn) begin
      if (hz.branchtaken) begin
        w_pcen      = 1'b1;
        w_ifiden    = 1'b1;
        w_ifidflush = 1'b1;
        w_ctrlsig   = 1'b1;
      end else if (w_stall) begin
        w_pcen      = 1'b0;
        w_ifiden    = 1'b0;
        w_ifidflush = 1'b0;
        w_ctrlsig   = 1'b1;
      end else begin
        w_pcen      = 1'b1;
        w_ifiden    = 1'b1;
        w_ifidflush = 1'b0;
        w_ctrlsig   = 1'b0;
      end
      // mdstart follows idexmd even if branchtaken is also seen.
      w_mdstart = (r_state == ST_RUN) && hz.idexmd;
      w_mddone  = w_busy && (r_mdcnt == '0);
    end
  end

  // Mul/div window FSM; reset aborts an active window without a done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_RUN;
      r_mdcnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (hz.idexmd) begin
            r_state <= ST_MDWAIT;
            r_mdcnt <= CNTW'(MDCYCLES - 1);
          end
        end
        ST_MDWAIT: begin
          // A second idexmd here is ignored: no restart.
          if (r_mdcnt == '0) begin
            r_state <= ST_RUN;
          end else begin
            r_mdcnt <= r_mdcnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_mdcnt <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC frozen; clear wins over increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stallcount <= '0;
    end else if (hz.stallclr) begin
      r_stallcount <= '0;
    end else if (!w_pcen && (r_stallcount != '1)) begin
      r_stallcount <= r_stallcount + 1'b1;
    end
  end

  assign hz.pcen       = w_pcen;
  assign hz.ifiden     = w_ifiden;
  assign hz.ifidflush  = w_ifidflush;
  assign hz.ctrlsig    = w_ctrlsig;
  assign hz.mdstart    = w_mdstart;
  assign hz.mdbusy     = rstn && w_busy;
  assign hz.mddone     = w_mddone;
  assign hz.stallcount = r_stallcount;
  assign hz.dbg_state  = r_state;
  assign hz.dbg_mdcnt  = r_mdcnt;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage semiMIPS pipeline.
- Detects load-use hazards between ID and EX, and owns the busy window of the iterative multiply/divide unit. It stalls any HI/LO or mul/div consumer in ID until that unit finishes.
- Squashes IF and ID on a taken branch resolved in EX.
- Drives the PC write enable, the IF/ID enable and flush, and the ID/EX control-zeroing mux. Keeps a saturating stall-cycle counter for performance checks.

Parameters:
REGW, 5, register-specifier width
MDCYCLES, 32, cycles the mul/div unit is busy after a start pulse (range 2..63)
CNTW, 6, width of the internal mul/div down-counter
STALLW, 16, width of the stall-cycle counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
idexrt  in  REGW  rt field of the instruction in EX
idexmemrd  in  1  instruction in EX is a load
ifidrs  in  REGW  rs field of the instruction in ID
ifidrt  in  REGW  rt field of the instruction in ID
idexmd  in  1  instruction in EX is mult/multu/div/divu
ifidmd  in  1  instruction in ID is mult/multu/div/divu
ifidhilo  in  1  instruction in ID is mfhi/mflo/mthi/mtlo
branchtaken  in  1  branch/jump in EX resolved taken this cycle
stallclr  in  1  synchronous clear of stallcount
pcen  out  1  PC write enable
ifiden  out  1  IF/ID register write enable
ifidflush  out  1  IF/ID register loads a NOP
ctrlsig  out  1  1 = ID/EX control fields forced to zero (bubble)
mdstart  out  1  one-cycle start pulse to the mul/div unit
mdbusy  out  1  mul/div unit occupied
mddone  out  1  one-cycle pulse on the last busy cycle
stallcount  out  STALLW  cycles with pcen=0 since reset/clear, saturating

Behaviour:
- The controller is implemented as a two-state FSM, RUN and MDWAIT, plus the down-counter mdcnt and the register stallcount.
- Outputs are combinational from the state, mdcnt and the inputs. Only the state, mdcnt and stallcount are registered.

Reset:
- While rstn=0, the FSM is held in RUN, mdcnt=0 and stallcount=0.
- Outputs during reset: pcen=0, ifiden=0, ifidflush=0, ctrlsig=1, mdstart=0, mdbusy=0, mddone=0.
- Reset asserted mid-MDWAIT aborts the busy window immediately. No mddone pulse is produced.

Hazard terms:
- loaduse = idexmemrd & (idexrt != 0) & ((idexrt == ifidrs) | (idexrt == ifidrt)). Register 0 never causes a stall.
- mdhaz = mdbusy & (ifidmd | ifidhilo).
- mdbusy = (state == MDWAIT).
- stall = loaduse | mdhaz.

Priority, highest first:
1. branchtaken=1: pcen=1, ifiden=1, ifidflush=1, ctrlsig=1. Any stall is suppressed because the ID instruction is wrong-path.
2. stall=1: pcen=0, ifiden=0, ifidflush=0, ctrlsig=1. IF and ID hold; a bubble enters EX.
3. Otherwise: pcen=1, ifiden=1, ifidflush=0, ctrlsig=0.

FSM:
- In RUN with idexmd=1: mdstart=1 in that cycle, mdcnt is loaded with MDCYCLES-1, and the next state is MDWAIT.
- In MDWAIT: mdcnt decrements by 1 each cycle.
  - When mdcnt==0, mddone=1 in that cycle and the next state is RUN.
  - Total mdbusy duration is exactly MDCYCLES cycles.
- idexmd=1 while in MDWAIT is ignored (no restart, no second mdstart). The mdhaz stall makes this unreachable in legal code.
- mdstart is only ever asserted in RUN.
- idexmd and branchtaken are both EX-stage flags of one instruction, so they are mutually exclusive. If both are seen, mdstart still follows idexmd.
- In the mddone cycle, mdbusy is still 1, so a waiting ID consumer stays stalled that cycle. It advances on the next cycle.

stallcount:
- Increments on every rising edge where pcen=0 and rstn=1.
- Saturates at 2^STALLW-1.
- stallclr=1 forces the count to 0 on that edge, taking precedence over the increment.

Test Plan:
1. Reset then release; idexmemrd=1, idexrt=1, ifidrt=1 for one cycle -> pcen=0, ifiden=0, ctrlsig=1 that cycle; stallcount=1 after the edge. Then idexrt=2 with ifidrs=ifidrt=1 -> pcen=1, ctrlsig=0.
2. idexmemrd=1, idexrt=0, ifidrs=0 -> no stall (pcen=1, ctrlsig=0). Register-0 exclusion.
3. idexmd=1 for one cycle with MDCYCLES=32 -> mdstart=1 that cycle; mdbusy=1 for exactly 32 cycles; mddone=1 only on the 32nd. ifidhilo=1 held throughout -> pcen=0 for all 32 busy cycles, pcen=1 on the cycle after mddone.
4. Load-use stall (idexmemrd=1, idexrt=3, ifidrs=3) with branchtaken=1 in the same cycle -> pcen=1, ifidflush=1, ctrlsig=1, and stallcount does not increment.
5. Drop rstn to 0 at busy cycle 10 of a mul/div -> mdbusy=0 and pcen=0 immediately, without waiting for a clock edge. After release: state RUN, mddone never pulsed, stallcount=0.
6. Force 65540 consecutive stall cycles -> stallcount holds at 65535. Pulse stallclr -> 0 on the next edge.
